// File: rtl/ssd_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per cycle) feeding the
// seven-segment display driver. The last result is held while a conversion runs.
module ssd_bcd_conv #(
  parameter int BIN_W      = 14,
  parameter int DIGITS     = 4,
  parameter int DATA_OUT_W = 4 * DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [DATA_OUT_W-1:0] data_out,
  output logic                  valid_out,
  output logic                  ovf
);

  // One spare digit above the displayed ones absorbs values up to 2^BIN_W-1.
  localparam int SCR_W = BIN_W + 4 * (DIGITS + 1);
  localparam int BCD_W = 4 * (DIGITS + 1);
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam longint unsigned MAX_VAL = 64'(10 ** DIGITS) - 64'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [SCR_W-1:0]      scr_q, scr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovfp_q, ovfp_d;
  logic [DATA_OUT_W-1:0] data_q, data_d;
  logic                  ovf_q, ovf_d;
  logic                  vout_q, vout_d;

  // One double-dabble iteration: correct every BCD nibble >= 5, then shift left.
  function automatic logic [SCR_W-1:0] dabble_step(input logic [SCR_W-1:0] s);
    logic [SCR_W-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (r[BIN_W + 4*i +: 4] >= 4'd5)
        r[BIN_W + 4*i +: 4] = r[BIN_W + 4*i +: 4] + 4'd3;
    end
    return {r[SCR_W-2:0], 1'b0};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      scr_q   <= '0;
      cnt_q   <= '0;
      ovfp_q  <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      vout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      ovfp_q  <= ovfp_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      vout_q  <= vout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    ovfp_d  = ovfp_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    vout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          scr_d   = {{BCD_W{1'b0}}, bin_in};
          cnt_d   = CNT_W'(BIN_W);
          ovfp_d  = (64'(bin_in) > MAX_VAL);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = dabble_step(scr_q);
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1))
          state_d = DONE;
      end
      DONE: begin
        // Out-of-range values saturate the display to all nines.
        data_d  = ovfp_q ? DATA_OUT_W'({DIGITS{4'h9}}) : scr_q[BIN_W +: DATA_OUT_W];
        ovf_d   = ovfp_q;
        vout_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_out = (state_q == IDLE);
  assign data_out  = data_q;
  assign valid_out = vout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ssd_bcd_conv.sv
// Randomized self-checking bench for ssd_bcd_conv against a decimal-digit reference model.
module tb_ssd_bcd_conv;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] bin_in;
  logic        valid_in;
  logic        ready_out;
  logic [15:0] data_out;
  logic        valid_out;
  logic        ovf;

  int n_vec = 0;
  int n_err = 0;

  ssd_bcd_conv #(.BIN_W(14), .DIGITS(4), .DATA_OUT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bin_in    (bin_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: decimal digits by division; anything above 9999 saturates.
  function automatic logic [15:0] ref_bcd(input int v);
    if (v > 9999) return 16'h9999;
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic ref_ovf(input int v);
    return (v > 9999);
  endfunction

  // Single conversion: waits for ready, applies one accept edge, then observes 20 edges.
  task automatic run_conv(input int v, output int lat, output logic [15:0] d,
                          output logic o, output int pulses, output int ready_low,
                          output logic held);
    logic [15:0] prev_d;
    logic        prev_o;
    @(negedge clk);
    for (int k = 0; k < 50 && !ready_out; k++) @(negedge clk);
    prev_d   = data_out;
    prev_o   = ovf;
    valid_in = 1'b1;
    bin_in   = 14'(v);
    @(posedge clk);
    #1;
    valid_in  = 1'b0;
    bin_in    = 14'($urandom);
    lat       = -1;
    d         = 16'hxxxx;
    o         = 1'bx;
    pulses    = 0;
    held      = 1'b1;
    ready_low = ready_out ? 0 : 1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (!ready_out) ready_low++;
      if (valid_out) begin
        pulses++;
        if (lat < 0) begin
          lat = i;
          d   = data_out;
          o   = ovf;
        end
      end
      if (i < 15 && (data_out !== prev_d || ovf !== prev_o)) held = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    valid_in = 1'b0;
    bin_in   = '0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (data_out !== 16'h0000) begin
      n_err++; $display("FAIL reset_data: got %h expected %h", data_out, 16'h0000);
    end
    n_vec++;
    if (ovf !== 1'b0) begin
      n_err++; $display("FAIL reset_ovf: got %b expected 0", ovf);
    end
    n_vec++;
    if (valid_out !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: got %b expected 0", valid_out);
    end
    n_vec++;
    if (ready_out !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got %b expected 1", ready_out);
    end
  endtask

  task automatic test_basic();
    int lat, pulses, rlow;
    logic [15:0] d;
    logic o, held;
    run_conv(1234, lat, d, o, pulses, rlow, held);
    n_vec++;
    if (lat !== 15) begin n_err++; $display("FAIL basic_latency: got %0d expected 15", lat); end
    n_vec++;
    if (pulses !== 1) begin n_err++; $display("FAIL basic_pulses: got %0d expected 1", pulses); end
    n_vec++;
    if (rlow !== 15) begin n_err++; $display("FAIL basic_ready_low: got %0d expected 15", rlow); end
    n_vec++;
    if (d !== ref_bcd(1234)) begin n_err++; $display("FAIL basic_data: got %h expected %h", d, ref_bcd(1234)); end
    n_vec++;
    if (o !== 1'b0) begin n_err++; $display("FAIL basic_ovf: got %b expected 0", o); end
    n_vec++;
    if (held !== 1'b1) begin n_err++; $display("FAIL basic_hold: output changed before result edge"); end
  endtask

  task automatic test_boundaries();
    int vals[3] = '{0, 9, 9999};
    int lat, pulses, rlow;
    logic [15:0] d;
    logic o, held;
    foreach (vals[k]) begin
      run_conv(vals[k], lat, d, o, pulses, rlow, held);
      n_vec++;
      if (d !== ref_bcd(vals[k])) begin
        n_err++; $display("FAIL bound_data(%0d): got %h expected %h", vals[k], d, ref_bcd(vals[k]));
      end
      n_vec++;
      if (o !== ref_ovf(vals[k])) begin
        n_err++; $display("FAIL bound_ovf(%0d): got %b expected %b", vals[k], o, ref_ovf(vals[k]));
      end
      n_vec++;
      if (pulses !== 1) begin
        n_err++; $display("FAIL bound_pulses(%0d): got %0d expected 1", vals[k], pulses);
      end
    end
  endtask

  task automatic test_overflow();
    int vals[3] = '{10000, 42, 16383};
    int lat, pulses, rlow;
    logic [15:0] d;
    logic o, held;
    foreach (vals[k]) begin
      run_conv(vals[k], lat, d, o, pulses, rlow, held);
      n_vec++;
      if (d !== ref_bcd(vals[k])) begin
        n_err++; $display("FAIL ovf_data(%0d): got %h expected %h", vals[k], d, ref_bcd(vals[k]));
      end
      n_vec++;
      if (o !== ref_ovf(vals[k])) begin
        n_err++; $display("FAIL ovf_flag(%0d): got %b expected %b", vals[k], o, ref_ovf(vals[k]));
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, pulses, rlow, stray;
    logic [15:0] d;
    logic o, held;
    @(negedge clk);
    for (int k = 0; k < 50 && !ready_out; k++) @(negedge clk);
    valid_in = 1'b1;
    bin_in   = 14'd8765;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_vec++;
    if (data_out !== 16'h0000) begin n_err++; $display("FAIL midrst_data: got %h expected 0000", data_out); end
    n_vec++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL midrst_ovf: got %b expected 0", ovf); end
    n_vec++;
    if (valid_out !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b expected 0", valid_out); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ready_out !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b expected 1", ready_out); end
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (valid_out) stray++;
    end
    n_vec++;
    if (stray !== 0) begin n_err++; $display("FAIL midrst_no_pulse: got %0d pulses expected 0", stray); end
    run_conv(8765, lat, d, o, pulses, rlow, held);
    n_vec++;
    if (d !== 16'h8765) begin n_err++; $display("FAIL midrst_redo_data: got %h expected 8765", d); end
    n_vec++;
    if (lat !== 15) begin n_err++; $display("FAIL midrst_redo_latency: got %0d expected 15", lat); end
  endtask

  task automatic test_back_to_back();
    int t1, t2, pulses;
    logic [15:0] d1, d2;
    t1 = -1; t2 = -1; pulses = 0; d1 = 'x; d2 = 'x;
    @(negedge clk);
    for (int k = 0; k < 50 && !ready_out; k++) @(negedge clk);
    valid_in = 1'b1;
    bin_in   = 14'd57;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 5) bin_in = 14'd300;
      if (i == 16) valid_in = 1'b0;
      if (valid_out) begin
        pulses++;
        if (t1 < 0) begin t1 = i; d1 = data_out; end
        else if (t2 < 0) begin t2 = i; d2 = data_out; end
      end
    end
    valid_in = 1'b0;
    n_vec++;
    if (d1 !== 16'h0057) begin n_err++; $display("FAIL b2b_first: got %h expected 0057", d1); end
    n_vec++;
    if (d2 !== 16'h0300) begin n_err++; $display("FAIL b2b_second: got %h expected 0300", d2); end
    n_vec++;
    if (t1 !== 15) begin n_err++; $display("FAIL b2b_first_latency: got %0d expected 15", t1); end
    n_vec++;
    if (t2 - t1 !== 16) begin n_err++; $display("FAIL b2b_spacing: got %0d expected 16", t2 - t1); end
    n_vec++;
    if (pulses !== 2) begin n_err++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
  endtask

  task automatic test_random();
    int v, lat, pulses, rlow;
    logic [15:0] d;
    logic o, held;
    for (int n = 0; n < 24; n++) begin
      v = (n % 4 == 0) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 9999));
      run_conv(v, lat, d, o, pulses, rlow, held);
      n_vec++;
      if (d !== ref_bcd(v) || o !== ref_ovf(v)) begin
        n_err++; $display("FAIL rand_conv(%0d): got %h/%b expected %h/%b", v, d, o, ref_bcd(v), ref_ovf(v));
      end
      n_vec++;
      if (lat !== 15 || pulses !== 1) begin
        n_err++; $display("FAIL rand_timing(%0d): got lat %0d pulses %0d expected 15/1", v, lat, pulses);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
